serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial WIDTH-bit adder built around a single one-bit full-adder cell.
- Loads two operands and a carry-in on a start handshake.
- Feeds one operand bit pair per clock (LSB first) into the cell, registering the cell's carry-out as the next carry-in.
- Shifts each sum bit into a result register.
- Area-lean alternative to a ripple chain of full-adder cells; sits between the operand source and the result consumer.

Parameters:
WIDTH, 8, operand/sum width in bits (>=2)

Ports:
clk    input   1      clock, rising edge
rst    input   1      synchronous reset, active-high
start  input   1      request; sampled when not busy
a      input   WIDTH  operand A, sampled with accepted start
b      input   WIDTH  operand B, sampled with accepted start
ci     input   1      carry-in, sampled with accepted start
busy   output  1      high while bits are being processed
done   output  1      one-cycle pulse: sum/co valid
sum    output  WIDTH  result, held until next accepted start
co     output  1      final carry-out, held with sum

Behaviour:
- Single clock domain. All state is updated on the rising edge of clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, busy=0, done=0, sum=0, co=0, bit counter=0, carry register=0, shift registers=0.
- States:
  - IDLE: busy=0, done=0. start=1 -> ADD.
  - ADD: busy=1.
  - DONE: busy=0, done=1. start=1 -> ADD; otherwise -> IDLE.
- Accepting a start (in IDLE or DONE):
  - Load A/B shift registers from a/b.
  - Load carry register from ci.
  - Clear bit counter.
  - Next state = ADD.
- In each ADD cycle:
  - The cell computes s and c from A[0], B[0] and the carry register.
  - Shift A and B right.
  - Shift s into the result MSB, result shifting right, so that after WIDTH shifts bit 0 is the LSB sum.
  - Carry register <= c.
  - Increment the counter.
  - When counter==WIDTH-1, next state = DONE.
  - On that final edge, sum <= completed result and co <= c.
- Latency: start sampled at edge T gives busy high for cycles T+1..T+WIDTH and done high in cycle T+WIDTH+1. Total is WIDTH+1 cycles per operation.
- start while busy=1: ignored. The a/b/ci values are not sampled and the operation in flight is unaffected.
- start in the DONE cycle is accepted (back-to-back). done is high in that cycle and busy rises on the next cycle.
- sum/co change only on the final ADD edge. Intermediate bits are never exposed on sum.
- Arithmetic: {co,sum} = a + b + ci, computed modulo 2^(WIDTH+1). There is no saturation.
- Reset mid-operation: abort. The next cycle shows the reset values, with no done pulse. start asserted together with rst is ignored.
- Bit counter width is $clog2(WIDTH). It never wraps inside an operation.

Optional Feature:
SERIAL_ADD_OVF_EN
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf = two's-complement overflow, i.e. the carry into the MSB XOR the final carry-out.
  - The carry into the MSB is captured on the final ADD edge, and ovf updates together with sum/co.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_add_pkg holds:
  - State encoding constants: ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2.
  - Default width constant SA_WIDTH_DEF=8.
- Sub-module serial_fa_bit: a purely combinational one-bit full adder (inputs a, b, ci; outputs s, co) instantiated once.
- The FSM, counter and shift registers live in serial_adder.

Test Plan:
1. WIDTH=8. rst held 2 cycles, then released: busy=0, done=0, sum=0x00, co=0.
2. start with a=0x3C, b=0x42, ci=0 at edge T: busy high T+1..T+8; done high only at T+9 with sum=0x7E, co=0; sum/co hold afterwards.
3. a=0xFF, b=0x01, ci=0 -> sum=0x00, co=1. Then a=0xFF, b=0xFF, ci=1 issued in the DONE cycle -> accepted back-to-back; result sum=0xFF, co=1.
4. start a=0x10, b=0x20 at T; at T+3 start a=0xAA, b=0x55 (ignored) -> done at T+9 with sum=0x30, co=0.
5. start a=0x0F, b=0x01; rst asserted at T+4 -> busy=0 next cycle, no done pulse, sum=0x00; a new start afterwards completes normally.
6. With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01, ci=0 -> sum=0x80, co=0, ovf=1. a=0xFF, b=0x01 -> ovf=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared constants and types for the bit-serial adder
//
// Purpose : state encoding and default width used by serial_adder.
// Ports   : none (package).

package serial_add_pkg;

  // Default operand/sum width.
  localparam int SA_WIDTH_DEF = 8;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_fa_bit.sv
// rtl/serial_fa_bit.sv - one-bit combinational full-adder cell
//
// Purpose : the single arithmetic cell that the serial adder reuses every cycle.
// Ports   :
//   a, b  in  1  operand bits
//   ci    in  1  carry in
//   s     out 1  sum bit
//   co    out 1  carry out

module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // p is the propagate term; it is shared by the sum and the carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built on one full-adder cell
//
// Purpose : on an accepted start, adds a + b + ci one bit per clock, LSB first,
//           and presents {co, sum} with a one-cycle done pulse.
//           Optional feature macro: SERIAL_ADD_OVF_EN (adds the ovf output).
// Ports   :
//   clk    in  1      clock, rising edge
//   rst    in  1      synchronous reset, active-high
//   start  in  1      request; sampled when not busy
//   a, b   in  WIDTH  operands, sampled with an accepted start
//   ci     in  1      carry-in, sampled with an accepted start
//   busy   out 1      high while bits are being processed
//   done   out 1      one-cycle pulse: sum/co valid
//   sum    out WIDTH  result, held until the next accepted start completes
//   co     out 1      final carry-out, held with sum
//   ovf    out 1      two's-complement overflow (SERIAL_ADD_OVF_EN only)

module serial_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_co;

  // The only arithmetic in the design: one cell fed from the shift-register LSBs.
  serial_fa_bit u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    co_d    = co_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ADD: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // Sum bits enter at the MSB, so after WIDTH shifts bit 0 holds the LSB sum.
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == CNT_LAST) begin
          // Counter is left at its last value so it never wraps mid-operation.
          state_d = ST_DONE;
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          co_d    = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB cell on this final step.
          ovf_d   = carry_q ^ fa_co;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the next-state decode.
    busy_d = (state_d == ST_ADD);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign co   = co_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard testbench for serial_adder

module tb_serial_adder;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         ci    = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  // Expected entries are {ovf, co, sum}.
  logic [W+1:0] exp_q[$];
  logic [W+1:0] hold_v   = '0;
  logic         rst_prev = 1'b1;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition, overflow as "signed result out of range".
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv);
    int   us;
    int   ss;
    logic ov;
    logic [W:0] r;
    us = int'(av) + int'(bv) + int'(cv);
    ss = int'($signed(av)) + int'($signed(bv)) + int'(cv);
    ov = (ss > (2 ** (W - 1)) - 1) || (ss < -(2 ** (W - 1)));
    r  = us[W:0];
    return {ov, r};
  endfunction

  // Monitor: reset flushes expectations; done pops and compares; otherwise outputs must hold.
  always @(posedge clk) rst_prev <= rst;

  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst_prev) begin
      exp_q.delete();
      hold_v = '0;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_sum", 32'(sum), 0);
      check("rst_co", 32'(co), 0);
`ifdef SERIAL_ADD_OVF_EN
      check("rst_ovf", 32'(ovf), 0);
`endif
    end else if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(done), 0);
      end else begin
        e = exp_q.pop_front();
        hold_v = e;
        check("result_sum", 32'(sum), 32'(e[W-1:0]));
        check("result_co", 32'(co), 32'(e[W]));
`ifdef SERIAL_ADD_OVF_EN
        check("result_ovf", 32'(ovf), 32'(e[W+1]));
`endif
      end
    end else begin
      check("hold_sum_co", 32'({co, sum}), 32'(hold_v[W:0]));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1ns after an edge when the DUT will accept at the next edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    start = 1'b1;
    a     = av;
    b     = bv;
    ci    = cv;
    exp_q.push_back(model(av, bv, cv));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Walks the WIDTH busy cycles; poke>0 raises an ignored start in that busy cycle.
  task automatic wait_done(input int poke);
    for (int i = 1; i <= W; i++) begin
      check("busy_hi", 32'(busy), 1);
      check("done_lo", 32'(done), 0);
      if (i == poke) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        ci    = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("done_hi", 32'(done), 1);
    check("busy_lo", 32'(busy), 0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset held for two edges.
    idle(2);
    rst = 1'b0;
    check("init_busy", 32'(busy), 0);
    check("init_done", 32'(done), 0);
    check("init_sum", 32'(sum), 0);
    check("init_co", 32'(co), 0);
    idle(1);

    // Basic add and hold afterwards.
    issue(8'h3C, 8'h42, 1'b0);
    wait_done(0);
    idle(3);
    check("post_done_lo", 32'(done), 0);

    // Carry out, then back-to-back start in the DONE cycle.
    issue(8'hFF, 8'h01, 1'b0);
    wait_done(0);
    issue(8'hFF, 8'hFF, 1'b1);
    wait_done(0);
    idle(2);

    // Start while busy is ignored.
    issue(8'h10, 8'h20, 1'b0);
    wait_done(3);
    idle(2);

    // Reset mid-operation aborts with no done pulse.
    issue(8'h0F, 8'h01, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      check("pre_abort_busy", 32'(busy), 1);
      if (i == 3) rst = 1'b1;
      @(posedge clk);
      #1;
    end
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_sum", 32'(sum), 0);
    rst = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      check("abort_no_done", 32'(done), 0);
      idle(1);
    end
    issue(8'h05, 8'h06, 1'b1);
    wait_done(0);
    idle(1);

    // start together with rst is ignored.
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h11;
    b     = 8'h22;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 32'(busy), 0);
    idle(2);
    check("rst_start_still_idle", 32'(busy), 0);

    // Signed overflow cases.
    issue(8'h7F, 8'h01, 1'b0);
    wait_done(0);
    issue(8'hFF, 8'h01, 1'b0);
    wait_done(0);
    issue(8'h80, 8'h80, 1'b0);
    wait_done(0);
    idle(1);

    // Randomised operations with random gaps, back-to-back starts and ignored pokes.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      issue(ra, rb, 1'($urandom));
      wait_done(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W)) : 0);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end

    idle(3);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
